sys_array_feeder: RTL
=====================

# sys_array_feeder

Front-end stage of the systolic array. It collects a weight matrix and issues a single `weight_load` pulse to the cell grid. It then takes input vectors through a valid/ready handshake and drives them into the array's row inputs with a diagonal skew, so that row r is delayed by r cycles to line up with the partial sums travelling down the columns. After the last vector it flushes zeros until the array drains, then pulses `done`.

## Interface
- DATA_WIDTH, 8, width of one data/weight element (signed, passed through unchanged)
- ARRAY_H, 4, number of array rows; also the number of elements per input vector
- ARRAY_W, 4, number of array columns; also the number of elements per weight row
- clk  in  1  clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begins a job; sampled only in IDLE
- w_valid / w_ready  in / out  1 / 1  weight-row handshake
- w_data  in  ARRAY_W*DATA_WIDTH  one weight row; element c at [c*DATA_WIDTH +: DATA_WIDTH]
- x_valid / x_ready  in / out  1 / 1  input-vector handshake
- x_data  in  ARRAY_H*DATA_WIDTH  one input vector; element r at [r*DATA_WIDTH +: DATA_WIDTH]
- x_last  in  1  marks the final vector of the job; qualified by x_valid&x_ready
- weight_load  out  1  one-cycle pulse to all cells
- weight_data  out  ARRAY_H*ARRAY_W*DATA_WIDTH  weight (r,c) at [(r*ARRAY_W+c)*DATA_WIDTH +: DATA_WIDTH]
- array_in  out  ARRAY_H*DATA_WIDTH  skewed row inputs; row r feeds the input_data of column 0, row r
- array_in_valid  out  ARRAY_H  per-row valid, skewed identically to the data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a job

## Operation
- **States:** IDLE, LOAD, APPLY, STREAM, FLUSH, DONE.
- **IDLE**
  - start=1 moves to LOAD.
  - x_ready=0 and w_ready=0.
- **LOAD**
  - w_ready=1.
  - Each handshake writes w_data into weight row `wrow`, then increments `wrow`.
  - Acceptance of row ARRAY_H-1 moves to APPLY.
- **APPLY** (exactly 1 cycle)
  - weight_load=1.
  - weight_data holds the full matrix, and stays unchanged until the next LOAD write.
  - Next state is STREAM.
- **STREAM**
  - x_ready=1.
  - On a handshake, stage-0 registers capture x_data with valid=1.
  - With no handshake (x_valid=0), stage 0 captures zeros with valid=0.
  - A handshake with x_last=1 moves to FLUSH.
- **FLUSH**
  - Lasts exactly ARRAY_H+ARRAY_W-1 cycles.
  - Counter width is clog2(ARRAY_H+ARRAY_W); it is loaded on entry and decremented each cycle.
  - Stage 0 captures zeros with valid=0.
  - Next state is DONE.
- **DONE** (1 cycle)
  - done=1.
  - Next state is IDLE.
- **Skew pipeline**
  - Row r is a shift register of depth r+1, stage 0 included.
  - It shifts every cycle in every state.
  - Outside STREAM it is fed zeros with valid=0.
  - No arithmetic is performed: elements are passed bit-exact.
- **start outside IDLE:** ignored.
- **Stray w_valid / x_valid** in states whose ready is low: ignored, no effect.
- **Reset (asynchronous, any time):**
  - State returns to IDLE.
  - All outputs go to 0, including weight_data and array_in.
  - All skew stages, row counter and flush counter are cleared.
  - A job interrupted mid-operation is abandoned; no done is issued.

## Timing
- Cycle k is the cycle immediately after the edge that accepts vector V.
  - array_in row r equals V[r] during cycle k+r.
  - array_in_valid[r]=1 during that same cycle.
- Back-to-back vectors occupy consecutive cycles on every row.
- weight_load is high for the single cycle after the edge that accepts the last weight row.
- The first x_ready=1 is in the cycle after APPLY; the minimum start-to-first-x_ready latency is ARRAY_H+2 cycles.
- Zeros fill the skew stages during weight loading, so the array sees only zero inputs before the first vector.
- done rises ARRAY_H+ARRAY_W cycles after the edge that accepts x_last.
- busy is high from the cycle after start is sampled through the DONE cycle inclusive.
- Minimal job: x_last on the very first vector is legal and gives one valid vector then a flush.

## Test plan
- **Reset:** assert reset_n=0 mid-clock with state STREAM.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release: busy=0, x_ready=0, w_ready=0.
- **Weight load (H=W=4):** start, then 4 rows {1,2,3,4}…{13,14,15,16} with w_valid held high.
  - w_ready is high for exactly 4 cycles.
  - weight_load pulses for exactly 1 cycle.
  - weight(2,1)=10.
- **Streaming:** vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} back-to-back, last on the third.
  - Row 0 shows 1,5,9 at k..k+2.
  - Row 3 shows 4,8,12 at k+3..k+5, with valid high only there.
  - FLUSH lasts 7 cycles; done rises 8 cycles after the last accept.
- **Bubbles:** x_valid pattern 1,0,0,1(last) with values {-1,…} and {-128,…}.
  - Rows carry zeros with valid=0 in the gaps.
  - Order is preserved and signed values pass bit-exact (-128 = 8'h80).
- **Stray inputs:** start pulsed during STREAM and during DONE; x_valid held high during LOAD.
  - No state change.
  - No x acceptance before STREAM.
- **Mid-job reset:** async reset during FLUSH, then a new start.
  - No done from the abandoned job.
  - The new job behaves exactly like the streaming case above.

Source files
------------

// File: rtl/sys_array_feeder.sv
// Systolic-array front end: loads the weight matrix, pulses weight_load, then feeds
// input vectors into the rows with a diagonal skew and flushes zeros until the array drains.
module sys_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_H    = 4,
  parameter int ARRAY_W    = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [ARRAY_W*DATA_WIDTH-1:0]          w_data,
  input  logic                                   x_valid,
  output logic                                   x_ready,
  input  logic [ARRAY_H*DATA_WIDTH-1:0]          x_data,
  input  logic                                   x_last,
  output logic                                   weight_load,
  output logic [ARRAY_H*ARRAY_W*DATA_WIDTH-1:0]  weight_data,
  output logic [ARRAY_H*DATA_WIDTH-1:0]          array_in,
  output logic [ARRAY_H-1:0]                     array_in_valid,
  output logic                                   busy,
  output logic                                   done
);

  localparam int ROW_BITS  = ARRAY_W * DATA_WIDTH;
  localparam int RW        = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1;
  localparam int FLUSH_LEN = ARRAY_H + ARRAY_W - 1;
  localparam int FW        = $clog2(ARRAY_H + ARRAY_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                      state;
  logic [RW-1:0]                   wrow;
  logic [FW-1:0]                   flush_cnt;
  logic [ARRAY_H*DATA_WIDTH-1:0]   feed_data;
  logic                            feed_valid;

  // Handshake readiness and status are pure decodes of state, so an async reset
  // clears them the instant reset_n falls.
  assign w_ready     = (state == S_LOAD);
  assign x_ready     = (state == S_STREAM);
  assign weight_load = (state == S_APPLY);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // NOTE: every output of always_comb is given a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    feed_data  = '0;
    feed_valid = 1'b0;
    if (x_valid && x_ready) begin
      feed_data  = x_data;
      feed_valid = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wrow        <= '0;
      flush_cnt   <= '0;
      weight_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          if (w_valid) begin
            weight_data[wrow*ROW_BITS +: ROW_BITS] <= w_data;
            if (wrow == RW'(ARRAY_H - 1)) begin
              wrow  <= '0;
              state <= S_APPLY;
            end else begin
              wrow <= wrow + 1'b1;
            end
          end
        end
        S_APPLY: state <= S_STREAM;
        S_STREAM: begin
          if (x_valid && x_last) begin
            state     <= S_FLUSH;
            flush_cnt <= FW'(FLUSH_LEN - 1);
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) state <= S_DONE;
          else                 flush_cnt <= flush_cnt - 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row r is a depth r+1 shift register; its last stage drives the array row.
  for (genvar r = 0; r < ARRAY_H; r++) begin : g_row
    logic [DATA_WIDTH-1:0] sd [0:r];
    logic                  sv [0:r];

    // NOTE: the skew stages are storage but are still reset, because the array must
    // see clean zeros (and no stray valid) on its rows straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s <= r; s++) begin
          sd[s] <= '0;
          sv[s] <= 1'b0;
        end
      end else begin
        sd[0] <= feed_data[r*DATA_WIDTH +: DATA_WIDTH];
        sv[0] <= feed_valid;
        for (int s = 1; s <= r; s++) begin
          sd[s] <= sd[s-1];
          sv[s] <= sv[s-1];
        end
      end
    end

    assign array_in[r*DATA_WIDTH +: DATA_WIDTH] = sd[r];
    assign array_in_valid[r]                    = sv[r];
  end

endmodule
